// File: rtl/lcd_sched_pkg.sv
// Shared definitions for the LCD update scheduler.
//   state_t      : scheduler FSM states
//   grant_t      : arbitration result (CRC slot, cfg slot, periodic refresh)
//   LCD_CRC_RST  : reset value of the CRC shadow register
//   LCD_OP_RST   : reset value of the display-option shadow register
//   cnt_w()      : counter width for a terminal count of n (minimum 1 bit)
package lcd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        HOLDOFF
    } state_t;

    typedef enum logic [1:0] {
        GNT_CRC,
        GNT_CFG,
        GNT_REF
    } grant_t;

    localparam logic [31:0] LCD_CRC_RST = 32'hFFFF_FFFF;
    localparam logic [1:0]  LCD_OP_RST  = 2'b00;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_sched_rr2.sv
// Two-way round-robin arbiter with a lower-priority refresh request.
//   clock, reset : system clock, synchronous active-high reset
//   req_crc      : CRC slot pending
//   req_cfg      : cfg slot pending
//   req_ref      : periodic refresh pending (served only when neither slot pends)
//   take         : the current grant is consumed this cycle
//   gnt_valid    : some request is being granted
//   gnt          : which request wins
// On a CRC/cfg tie the requester that did not win last time is chosen.
// last_grant resets to GNT_CFG so the first tie goes to CRC; refresh grants
// leave it untouched.
module lcd_sched_rr2 import lcd_sched_pkg::*; (
    input  logic   clock,
    input  logic   reset,
    input  logic   req_crc,
    input  logic   req_cfg,
    input  logic   req_ref,
    input  logic   take,
    output logic   gnt_valid,
    output grant_t gnt
);

    grant_t last_grant;

    always_comb begin
        gnt_valid = 1'b1;
        gnt       = GNT_REF;
        if (req_crc && req_cfg) begin
            gnt = (last_grant == GNT_CRC) ? GNT_CFG : GNT_CRC;
        end else if (req_crc) begin
            gnt = GNT_CRC;
        end else if (req_cfg) begin
            gnt = GNT_CFG;
        end else if (req_ref) begin
            gnt = GNT_REF;
        end else begin
            gnt_valid = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= GNT_CFG;
        end else if (take && gnt_valid && (gnt != GNT_REF)) begin
            last_grant <= gnt;
        end
    end

endmodule

// File: rtl/lcd_update_scheduler.sv
// Shares the LCD driver between the CRC engine and the user-config path.
// Requests are latched into slots, arbitrated round-robin, copied into stable
// shadow registers driving the lcd inputs, and launched with a 1-cycle start.
// The scheduler then waits for lcd_done (bounded by TIMEOUT_CYCLES), enforces
// a GAP_CYCLES hold-off, and re-issues the current content after
// REFRESH_CYCLES idle cycles (0 disables refresh).
//   clock, reset          : system clock, synchronous active-high reset
//   crc_valid/value/status: CRC result pulse and payload
//   cfg_valid/cfg_op      : display option pulse and payload
//   err_clr               : clears timeout_err
//   lcd_done              : driver finished (honoured only in WAIT_DONE)
//   lcd_start             : 1-cycle launch pulse to the driver
//   lcd_usr_op/crc/status : shadow registers feeding the driver
//   crc_ack/cfg_ack       : 1-cycle pulse when a slot is handed over
//   sched_busy            : FSM not in IDLE
//   timeout_err           : sticky driver-timeout flag
module lcd_update_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned REFRESH_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        crc_valid,
    input  logic [31:0] crc_value,
    input  logic        crc_status,
    input  logic        cfg_valid,
    input  logic [1:0]  cfg_op,
    input  logic        err_clr,
    input  logic        lcd_done,
    output logic        lcd_start,
    output logic [1:0]  lcd_usr_op,
    output logic [31:0] lcd_crc,
    output logic        lcd_crc_status,
    output logic        crc_ack,
    output logic        cfg_ack,
    output logic        sched_busy,
    output logic        timeout_err
);

    import lcd_sched_pkg::*;

    localparam int unsigned TO_W  = cnt_w(TIMEOUT_CYCLES);
    localparam int unsigned REF_W = cnt_w(REFRESH_CYCLES);
    localparam int unsigned GAP_W = cnt_w(GAP_CYCLES);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam bit               REF_EN   = (REFRESH_CYCLES != 0);

    state_t            state;
    logic [31:0]       crc_slot_val;
    logic              crc_slot_st;
    logic              crc_pend;
    logic [1:0]        cfg_slot_op;
    logic              cfg_pend;
    logic              refresh_pend;
    logic [TO_W-1:0]   wait_cnt;
    logic [REF_W-1:0]  ref_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic              gnt_valid;
    grant_t            gnt;
    logic              take;
    logic              take_crc;
    logic              take_cfg;

    assign take     = (state == IDLE) && gnt_valid;
    assign take_crc = take && (gnt == GNT_CRC);
    assign take_cfg = take && (gnt == GNT_CFG);

    assign sched_busy = (state != IDLE);

    lcd_sched_rr2 u_rr2 (
        .clock     (clock),
        .reset     (reset),
        .req_crc   (crc_pend),
        .req_cfg   (cfg_pend),
        .req_ref   (refresh_pend),
        .take      (take),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            lcd_start      <= 1'b0;
            lcd_usr_op     <= LCD_OP_RST;
            lcd_crc        <= LCD_CRC_RST;
            lcd_crc_status <= 1'b0;
            crc_ack        <= 1'b0;
            cfg_ack        <= 1'b0;
            timeout_err    <= 1'b0;
            crc_slot_val   <= LCD_CRC_RST;
            crc_slot_st    <= 1'b0;
            crc_pend       <= 1'b0;
            cfg_slot_op    <= LCD_OP_RST;
            cfg_pend       <= 1'b0;
            refresh_pend   <= 1'b0;
            wait_cnt       <= '0;
            ref_cnt        <= '0;
            gap_cnt        <= '0;
        end else begin
            lcd_start <= 1'b0;
            crc_ack   <= 1'b0;
            cfg_ack   <= 1'b0;

            // Capture in any state; a pulse arriving on the grant edge keeps
            // its pend set so the fresh data is issued next round.
            if (crc_valid) begin
                crc_slot_val <= crc_value;
                crc_slot_st  <= crc_status;
            end
            if (cfg_valid) begin
                cfg_slot_op <= cfg_op;
            end
            crc_pend <= crc_valid | (crc_pend & ~take_crc);
            cfg_pend <= cfg_valid | (cfg_pend & ~take_cfg);

            // A timeout set later in this block overrides a same-cycle clear.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (take) begin
                        refresh_pend <= 1'b0;
                        case (gnt)
                            GNT_CRC: begin
                                lcd_crc        <= crc_slot_val;
                                lcd_crc_status <= crc_slot_st;
                                crc_ack        <= 1'b1;
                            end
                            GNT_CFG: begin
                                lcd_usr_op <= cfg_slot_op;
                                cfg_ack    <= 1'b1;
                            end
                            default: ;
                        endcase
                        state <= ISSUE;
                    end else if (REF_EN) begin
                        if (ref_cnt == REF_LAST) begin
                            refresh_pend <= 1'b1;
                        end else begin
                            ref_cnt <= ref_cnt + 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    lcd_start <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (lcd_done) begin
                        gap_cnt <= '0;
                        ref_cnt <= '0;
                        state   <= HOLDOFF;
                    end else if (wait_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        ref_cnt     <= '0;
                        state       <= HOLDOFF;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                HOLDOFF: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_update_scheduler.sv
// Directed testbench for lcd_update_scheduler with TIMEOUT_CYCLES=20,
// REFRESH_CYCLES=100, GAP_CYCLES=4. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point, reflecting that edge.
module tb_lcd_update_scheduler;

    logic        clock;
    logic        reset;
    logic        crc_valid;
    logic [31:0] crc_value;
    logic        crc_status;
    logic        cfg_valid;
    logic [1:0]  cfg_op;
    logic        err_clr;
    logic        lcd_done;
    logic        lcd_start;
    logic [1:0]  lcd_usr_op;
    logic [31:0] lcd_crc;
    logic        lcd_crc_status;
    logic        crc_ack;
    logic        cfg_ack;
    logic        sched_busy;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_crc_ack = 0;
    int n_cfg_ack = 0;

    lcd_update_scheduler #(
        .TIMEOUT_CYCLES (20),
        .REFRESH_CYCLES (100),
        .GAP_CYCLES     (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .crc_valid      (crc_valid),
        .crc_value      (crc_value),
        .crc_status     (crc_status),
        .cfg_valid      (cfg_valid),
        .cfg_op         (cfg_op),
        .err_clr        (err_clr),
        .lcd_done       (lcd_done),
        .lcd_start      (lcd_start),
        .lcd_usr_op     (lcd_usr_op),
        .lcd_crc        (lcd_crc),
        .lcd_crc_status (lcd_crc_status),
        .crc_ack        (crc_ack),
        .cfg_ack        (cfg_ack),
        .sched_busy     (sched_busy),
        .timeout_err    (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (lcd_start) n_start   <= n_start + 1;
        if (crc_ack)   n_crc_ack <= n_crc_ack + 1;
        if (cfg_ack)   n_cfg_ack <= n_cfg_ack + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic pulse(input logic do_crc, input logic [31:0] v, input logic st,
                         input logic do_cfg, input logic [1:0] op);
        crc_valid  = do_crc;
        crc_value  = v;
        crc_status = st;
        cfg_valid  = do_cfg;
        cfg_op     = op;
        tick();
        crc_valid  = 1'b0;
        cfg_valid  = 1'b0;
    endtask

    task automatic pulse_done();
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 16 && sched_busy; i++) tick();
        check({tag, "_idle"}, sched_busy, 1'b0);
    endtask

    // Grant edge: ack visible one cycle, lcd_start the cycle after with shadows.
    task automatic check_grant(input string tag, input logic ca, input logic fa,
                               input logic [31:0] crc, input logic st, input logic [1:0] op);
        tick();
        check({tag, "_crc_ack"}, crc_ack, ca);
        check({tag, "_cfg_ack"}, cfg_ack, fa);
        check({tag, "_start_early"}, lcd_start, 1'b0);
        tick();
        check({tag, "_start"}, lcd_start, 1'b1);
        check({tag, "_lcd_crc"}, lcd_crc, crc);
        check({tag, "_status"}, lcd_crc_status, st);
        check({tag, "_usr_op"}, lcd_usr_op, op);
    endtask

    int s0, s1;

    initial begin
        reset = 1'b1; crc_valid = 1'b0; crc_value = '0; crc_status = 1'b0;
        cfg_valid = 1'b0; cfg_op = 2'b00; err_clr = 1'b0; lcd_done = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // 1: reset values, then refresh after 100 idle cycles, no acks
        check("rst_start", lcd_start, 1'b0);
        check("rst_op", lcd_usr_op, 2'b00);
        check("rst_crc", lcd_crc, 32'hFFFF_FFFF);
        check("rst_status", lcd_crc_status, 1'b0);
        check("rst_acks", {crc_ack, cfg_ack}, 2'b00);
        check("rst_busy", sched_busy, 1'b0);
        check("rst_terr", timeout_err, 1'b0);
        s0 = n_start;
        repeat (101) tick();
        check("ref_no_early_start", n_start - s0, 0);
        check("ref_busy", sched_busy, 1'b1);
        tick();
        check("ref_start", lcd_start, 1'b1);
        check("ref_crc", lcd_crc, 32'hFFFF_FFFF);
        check("ref_no_ack", n_crc_ack + n_cfg_ack, 0);
        pulse_done();
        wait_idle("ref");

        // 2: single CRC request
        pulse(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'b00);
        check_grant("t2", 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 2'b00);
        pulse_done();
        wait_idle("t2");

        // 3: ties alternate; first tie after reset goes to CRC
        do_reset();
        pulse(1'b1, 32'h33, 1'b0, 1'b1, 2'b10);
        check_grant("t3a", 1'b1, 1'b0, 32'h33, 1'b0, 2'b00);
        pulse_done();
        repeat (4) tick();
        check_grant("t3b", 1'b0, 1'b1, 32'h33, 1'b0, 2'b10);
        pulse_done();
        wait_idle("t3b");
        pulse(1'b1, 32'h44, 1'b1, 1'b0, 2'b00);
        check_grant("t3c", 1'b1, 1'b0, 32'h44, 1'b1, 2'b10);
        pulse_done();
        wait_idle("t3c");
        pulse(1'b1, 32'h55, 1'b0, 1'b1, 2'b01);
        check_grant("t3d", 1'b0, 1'b1, 32'h44, 1'b1, 2'b01);
        pulse_done();
        repeat (4) tick();
        check_grant("t3e", 1'b1, 1'b0, 32'h55, 1'b0, 2'b01);
        pulse_done();
        wait_idle("t3e");

        // 4: two CRC pulses during WAIT_DONE collapse into one issue of the latest
        s1 = n_crc_ack;
        pulse(1'b1, 32'h66, 1'b0, 1'b0, 2'b00);
        check_grant("t4a", 1'b1, 1'b0, 32'h66, 1'b0, 2'b01);
        pulse(1'b1, 32'h11, 1'b0, 1'b0, 2'b00);
        pulse(1'b1, 32'h22, 1'b1, 1'b0, 2'b00);
        pulse_done();
        repeat (4) tick();
        check_grant("t4b", 1'b1, 1'b0, 32'h22, 1'b1, 2'b01);
        pulse_done();
        wait_idle("t4b");
        s0 = n_start;
        repeat (20) tick();
        check("t4_no_extra_start", n_start - s0, 0);
        check("t4_crc_ack_count", n_crc_ack - s1, 2);

        // 5: driver timeout, sticky flag, done ignored in IDLE, err_clr
        pulse(1'b1, 32'h77, 1'b0, 1'b0, 2'b00);
        check_grant("t5a", 1'b1, 1'b0, 32'h77, 1'b0, 2'b01);
        repeat (19) tick();
        check("t5_terr_before", timeout_err, 1'b0);
        check("t5_busy_wait", sched_busy, 1'b1);
        tick();
        check("t5_terr_set", timeout_err, 1'b1);
        repeat (4) tick();
        check("t5_idle", sched_busy, 1'b0);
        check("t5_terr_sticky", timeout_err, 1'b1);
        pulse_done();
        check("t5_done_ignored", sched_busy, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_terr_clr", timeout_err, 1'b0);

        // 6: reset in WAIT_DONE with cfg pending
        pulse(1'b1, 32'h88, 1'b1, 1'b0, 2'b00);
        check_grant("t6a", 1'b1, 1'b0, 32'h88, 1'b1, 2'b01);
        pulse(1'b0, 32'h0, 1'b0, 1'b1, 2'b11);
        s0 = n_start;
        s1 = n_cfg_ack;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_busy", sched_busy, 1'b0);
        check("t6_crc", lcd_crc, 32'hFFFF_FFFF);
        check("t6_op", lcd_usr_op, 2'b00);
        check("t6_status", lcd_crc_status, 1'b0);
        repeat (20) tick();
        check("t6_no_cfg_ack", n_cfg_ack - s1, 0);
        check("t6_no_start", n_start - s0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
